// File: rtl/axi4lite_slave_regbank.sv
// AXI4-Lite slave exposing G_NB_REGS byte-strobed registers with SLVERR on out-of-range words.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valids hold their payload until then.
module axi4lite_slave_regbank #(
  parameter int G_AXI4_LITE_ADDR_WIDTH = 32,
  parameter int G_AXI4_LITE_DATA_WIDTH = 32,
  parameter int G_NB_REGS              = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          awvalid,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]             awaddr,
  input  logic [2:0]                                    awprot,
  output logic                                          awready,
  input  logic                                          wvalid,
  input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]             wdata,
  input  logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]           wstrb,
  output logic                                          wready,
  output logic                                          bvalid,
  output logic [1:0]                                    bresp,
  input  logic                                          bready,
  input  logic                                          arvalid,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]             araddr,
  input  logic [2:0]                                    arprot,
  output logic                                          arready,
  output logic                                          rvalid,
  output logic [G_AXI4_LITE_DATA_WIDTH-1:0]             rdata,
  output logic [1:0]                                    rresp,
  input  logic                                          rready,
  output logic [G_NB_REGS*G_AXI4_LITE_DATA_WIDTH-1:0]   reg_out,
  output logic [G_NB_REGS-1:0]                          wr_pulse
);
  localparam int DW  = G_AXI4_LITE_DATA_WIDTH;
  localparam int AW  = G_AXI4_LITE_ADDR_WIDTH;
  localparam int SW  = DW / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW  = AW - LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DW-1:0] regs [G_NB_REGS];
  w_state_t      w_state, w_state_nx;
  r_state_t      r_state, r_state_nx;
  logic          awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
  logic          aw_hs, w_hs, ar_hs, w_apply;
  logic [AW-1:0] awaddr_q, wr_addr;
  logic [DW-1:0] wdata_q, wr_data, rd_word;
  logic [SW-1:0] wstrb_q, wr_strb;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          wr_ok, rd_ok;
  logic          unused_ok;

  assign unused_ok = ^{awprot, arprot, awaddr[LSB-1:0], araddr[LSB-1:0]};

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;

  // The second handshake may arrive in the same cycle as the first; bypass the latches then.
  assign wr_addr = aw_hs ? awaddr : awaddr_q;
  assign wr_data = w_hs ? wdata : wdata_q;
  assign wr_strb = w_hs ? wstrb : wstrb_q;
  assign wr_idx  = wr_addr[AW-1:LSB];
  assign wr_ok   = wr_idx < IW'(G_NB_REGS);
  assign w_apply = (w_state != W_RESP) && (w_state_nx == W_RESP);

  assign rd_idx = araddr[AW-1:LSB];
  assign rd_ok  = rd_idx < IW'(G_NB_REGS);

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < G_NB_REGS; k++)
      if (rd_idx == IW'(k)) rd_word = regs[k];
  end

  for (genvar k = 0; k < G_NB_REGS; k++) begin : g_out
    assign reg_out[k*DW +: DW] = regs[k];
  end

  // Write FSM: state register (ready/valid are registered alongside it)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      w_state <= w_state_nx;
      awready <= awready_d;
      wready  <= wready_d;
      bvalid  <= bvalid_d;
    end
  end

  always_comb begin
    w_state_nx = w_state;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_nx = W_RESP;
        else if (aw_hs)    w_state_nx = W_HAVE_AW;
        else if (w_hs)     w_state_nx = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)             w_state_nx = W_RESP;
      W_HAVE_W:  if (aw_hs)            w_state_nx = W_RESP;
      W_RESP:    if (bvalid && bready) w_state_nx = W_IDLE;
      default:                         w_state_nx = W_IDLE;
    endcase
  end

  always_comb begin
    awready_d = (w_state_nx == W_IDLE) || (w_state_nx == W_HAVE_W);
    wready_d  = (w_state_nx == W_IDLE) || (w_state_nx == W_HAVE_AW);
    bvalid_d  = (w_state_nx == W_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < G_NB_REGS; k++) regs[k] <= '0;
      wr_pulse <= '0;
      bresp    <= RESP_OKAY;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      wr_pulse <= '0;
      if (aw_hs) awaddr_q <= awaddr;
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (w_apply) begin
        bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        for (int k = 0; k < G_NB_REGS; k++) begin
          if (wr_ok && (wr_idx == IW'(k))) begin
            wr_pulse[k] <= 1'b1;
            for (int b = 0; b < SW; b++)
              if (wr_strb[b]) regs[k][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read FSM: reads sample regs before any same-edge write lands, so they see the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
    end else begin
      r_state <= r_state_nx;
      arready <= arready_d;
      rvalid  <= rvalid_d;
    end
  end

  always_comb begin
    r_state_nx = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)             r_state_nx = R_DATA;
      R_DATA:  if (rvalid && rready)  r_state_nx = R_IDLE;
      default:                        r_state_nx = R_IDLE;
    endcase
  end

  always_comb begin
    arready_d = (r_state_nx == R_IDLE);
    rvalid_d  = (r_state_nx == R_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
      rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata <= rd_word;
      rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end
endmodule

// File: tb/tb_axi4lite_slave_regbank.sv
// Bench for axi4lite_slave_regbank: directed steps then random traffic against an array model.
module tb_axi4lite_slave_regbank;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              awvalid, wvalid, bready, arvalid, rready;
  logic [AW-1:0]     awaddr, araddr;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              awready, wready, bvalid, arready, rvalid;
  logic [1:0]        bresp, rresp;
  logic [DW-1:0]     rdata;
  logic [NR*DW-1:0]  reg_out;
  logic [NR-1:0]     wr_pulse;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] model [NR];

  axi4lite_slave_regbank #(
    .G_AXI4_LITE_ADDR_WIDTH(AW),
    .G_AXI4_LITE_DATA_WIDTH(DW),
    .G_NB_REGS(NR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awaddr(awaddr), .awprot(3'b000), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arprot(3'b000), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] exp_regs();
    logic [511:0] r = '0;
    for (int k = 0; k < NR; k++) r[k*DW +: DW] = model[k];
    return r;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, new_v, input logic [3:0] strb);
    logic [DW-1:0] r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_pend = 1, w_pend = 1, aw_hit, w_hit;
    int c = 0;
    int idx = int'(addr >> 2);
    logic [1:0] er;
    logic [NR-1:0] ep;
    awaddr = addr; wdata = data; wstrb = strb;
    while ((aw_pend || w_pend) && c < 50) begin
      awvalid = aw_pend && (c >= aw_dly);
      wvalid  = w_pend && (c >= w_dly);
      aw_hit = awvalid && awready;
      w_hit  = wvalid && wready;
      tick();
      c++;
      if (aw_hit) aw_pend = 0;
      if (w_hit) w_pend = 0;
      if (!w_pend && aw_pend) begin
        chk("wready_drop", wready, 1'b0);
        chk("awready_keep", awready, 1'b1);
      end
      if (!aw_pend && w_pend) begin
        chk("awready_drop", awready, 1'b0);
        chk("wready_keep", wready, 1'b1);
      end
    end
    awvalid = 0; wvalid = 0;
    if (aw_pend || w_pend) chk("write_timeout", 1'b0, 1'b1);
    if (idx < NR) begin
      model[idx] = merge(model[idx], data, strb);
      ep = NR'(1) << idx;
      er = 2'b00;
    end else begin
      ep = '0;
      er = 2'b10;
    end
    chk("bvalid_rise", bvalid, 1'b1);
    chk("bresp", bresp, er);
    chk("wr_pulse", wr_pulse, ep);
    chk("reg_out", reg_out, exp_regs());
    for (int i = 0; i < b_dly; i++) begin
      tick();
      chk("bvalid_hold", bvalid, 1'b1);
      chk("bresp_hold", bresp, er);
      chk("aw_w_ready_hold", {awready, wready}, 2'b00);
      chk("wr_pulse_once", wr_pulse, '0);
    end
    bready = 1;
    tick();
    bready = 0;
    chk("bvalid_fall", bvalid, 1'b0);
    chk("aw_w_ready_back", {awready, wready}, 2'b11);
    chk("wr_pulse_clear", wr_pulse, '0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    bit hit = 0;
    int c = 0;
    int idx = int'(addr >> 2);
    logic [DW-1:0] ed;
    logic [1:0] er;
    repeat (ar_dly) tick();
    araddr = addr;
    arvalid = 1;
    while (!hit && c < 50) begin
      hit = arready;
      tick();
      c++;
    end
    arvalid = 0;
    if (!hit) chk("read_timeout", 1'b0, 1'b1);
    ed = (idx < NR) ? model[idx] : '0;
    er = (idx < NR) ? 2'b00 : 2'b10;
    chk("rvalid_rise", rvalid, 1'b1);
    chk("rdata", rdata, ed);
    chk("rresp", rresp, er);
    chk("arready_drop", arready, 1'b0);
    for (int i = 0; i < r_dly; i++) begin
      tick();
      chk("rvalid_hold", rvalid, 1'b1);
      chk("rdata_hold", rdata, ed);
      chk("rresp_hold", rresp, er);
      chk("arready_hold", arready, 1'b0);
    end
    rready = 1;
    tick();
    rready = 0;
    chk("rvalid_fall", rvalid, 1'b0);
    chk("arready_back", arready, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] old_v;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    for (int k = 0; k < NR; k++) model[k] = '0;
    rst_n = 1;
    #3 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_readys", {awready, wready, arready}, 3'b000);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_resps", {bresp, rresp}, 4'b0000);
    chk("rst_rdata", rdata, '0);
    chk("rst_reg_out", reg_out, '0);
    chk("rst_wr_pulse", wr_pulse, '0);
    rst_n = 1;
    chk("release_readys_low", {awready, wready, arready}, 3'b000);
    tick();
    chk("release_readys_high", {awready, wready, arready}, 3'b111);

    // Basic write/read, W leading AW, byte strobes
    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h04, 0, 0);
    do_write(32'h08, 32'h11223344, 4'hF, 3, 0, 0);
    chk("reg2_full", reg_out[2*DW +: DW], 32'h11223344);
    do_write(32'h08, 32'hAABBCCDD, 4'h5, 0, 0, 0);
    chk("reg2_strb", reg_out[2*DW +: DW], 32'h11BB33DD);
    do_write(32'h14, 32'h0BADF00D, 4'hF, 0, 2, 0);

    // Out of range, back-pressure, zero strobe, bready early
    do_write(32'h40, 32'h12345678, 4'hF, 0, 0, 0);
    do_read(32'h40, 0, 0);
    do_write(32'h0C, 32'h01020304, 4'hF, 0, 0, 5);
    do_read(32'h04, 1, 5);
    do_write(32'h06, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    bready = 1;
    do_write(32'h3C, 32'hA5A5A5A5, 4'hC, 0, 0, 0);

    // Read and write to the same register on the same edge
    old_v = model[3];
    awaddr = 32'h0C; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 32'h0C;
    awvalid = 1; wvalid = 1; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    model[3] = 32'hCAFEF00D;
    chk("same_edge_old_rdata", rdata, old_v);
    chk("same_edge_valids", {bvalid, rvalid}, 2'b11);
    chk("same_edge_reg_out", reg_out, exp_regs());
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
    chk("same_edge_done", {bvalid, rvalid}, 2'b00);

    // Reset while in W_HAVE_AW and R_DATA
    awaddr = 32'h10; awvalid = 1; araddr = 32'h04; arvalid = 1;
    tick();
    awvalid = 0; arvalid = 0;
    chk("pre_rst_wstate", {awready, wready}, 2'b01);
    chk("pre_rst_rvalid", rvalid, 1'b1);
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < NR; k++) model[k] = '0;
    chk("mid_rst_readys", {awready, wready, arready}, 3'b000);
    chk("mid_rst_valids", {bvalid, rvalid}, 2'b00);
    chk("mid_rst_reg_out", reg_out, exp_regs());
    @(posedge clk);
    #1 rst_n = 1;
    tick();
    chk("post_rst_readys", {awready, wready, arready}, 3'b111);
    do_write(32'h10, 32'h55AA55AA, 4'hF, 1, 0, 1);
    do_read(32'h10, 0, 1);

    // Random traffic, including unaligned and out-of-range addresses
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
